// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-8 dispatch block: FSM encoding, channel
// count and select width.
package demux_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // One-hot decode of a channel select.
    function automatic logic [NUM_CH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_CH-1:0] oh;
        oh = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_ptr3.sv
// 3-bit wrapping counter with enable; used as the round-robin destination pointer.
module rr_ptr3
    import demux_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [SEL_W-1:0] count
);

    logic [SEL_W-1:0] count_reg;
    logic [SEL_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (en) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/demux_dispatch_8.sv
// Single-entry dispatch buffer that steers each accepted item to one of eight
// channels, either by explicit destination or round-robin.
module demux_dispatch_8
    import demux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]  in_dest,
    input  logic              mode,
    output logic [DATA_W-1:0] out_data,
    output logic [SEL_W-1:0]  out_sel,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready,
    output logic [7:0]        sent_cnt
);

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic [SEL_W-1:0]  sel_reg, sel_next;
    logic [7:0]        sent_cnt_reg, sent_cnt_next;
    logic [SEL_W-1:0]  rr_ptr;
    logic              up_xfer;
    logic              dn_xfer;
    logic              sel_ready;

    // Only the ready bit of the currently selected channel matters.
    assign sel_ready = out_ready[sel_reg];

    assign dn_xfer = (state_reg == FULL) && sel_ready;
    assign up_xfer = in_valid && in_ready;

    rr_ptr3 u_rr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (up_xfer && mode),
        .count (rr_ptr)
    );

    always_comb begin
        state_next    = state_reg;
        data_next     = data_reg;
        sel_next      = sel_reg;
        sent_cnt_next = sent_cnt_reg;
        in_ready      = 1'b0;

        if (rst_n) begin
            case (state_reg)
                EMPTY:   in_ready = 1'b1;
                FULL:    in_ready = sel_ready;
                default: in_ready = 1'b0;
            endcase
        end

        case (state_reg)
            EMPTY: begin
                if (up_xfer) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (dn_xfer && !up_xfer) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase

        // Destination is frozen at acceptance so a later mode flip cannot
        // re-route an item already held.
        if (up_xfer) begin
            data_next = in_data;
            sel_next  = mode ? rr_ptr : in_dest;
        end

        if (dn_xfer) begin
            sent_cnt_next = sent_cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= EMPTY;
            data_reg     <= '0;
            sel_reg      <= '0;
            sent_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            data_reg     <= data_next;
            sel_reg      <= sel_next;
            sent_cnt_reg <= sent_cnt_next;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_valid
            assign out_valid[gi] = (state_reg == FULL) && (sel_reg == SEL_W'(gi));
        end
    endgenerate

    assign out_data = data_reg;
    assign out_sel  = sel_reg;
    assign sent_cnt = sent_cnt_reg;

endmodule

// File: tb/tb_demux_dispatch_8.sv
// Directed bench for demux_dispatch_8: reset, directed, round-robin, stall,
// simultaneous transfer, counter wrap and mid-stream reset.
module tb_demux_dispatch_8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_dest;
    logic       mode;
    logic [7:0] out_data;
    logic [2:0] out_sel;
    logic [7:0] out_valid;
    logic [7:0] out_ready;
    logic [7:0] sent_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    demux_dispatch_8 #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .mode      (mode),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sent_cnt  (sent_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h33;
        in_dest   = 3'd5;
        mode      = 1'b0;
        out_ready = 8'hFF;

        // Reset held with an item offered: nothing may be accepted.
        tick();
        tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 8'h00);
        chk("rst_sent_cnt", sent_cnt, 0);
        chk("rst_out_sel", out_sel, 0);
        chk("rst_out_data", out_data, 0);

        rst_n    = 1'b1;
        in_valid = 1'b0;
        tick();
        chk("empty_in_ready", in_ready, 1);
        chk("empty_out_valid", out_valid, 8'h00);

        // Directed item to channel 5.
        mode     = 1'b0;
        in_dest  = 3'd5;
        in_data  = 8'hA5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("dir_out_valid", out_valid, 8'h20);
        chk("dir_out_sel", out_sel, 5);
        chk("dir_out_data", out_data, 8'hA5);
        tick();
        chk("dir_sent_cnt", sent_cnt, 1);
        chk("dir_drained", out_valid, 8'h00);

        // Ten back-to-back round-robin items.
        mode     = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 8'h10 + 8'(i);
            tick();
            $display("rr item %0d sel=%0d data=%0h valid=%0h", i, out_sel, out_data, out_valid);
            chk($sformatf("rr_sel_%0d", i), out_sel, i % 8);
            chk($sformatf("rr_valid_%0d", i), out_valid, 32'h1 << (i % 8));
            chk($sformatf("rr_data_%0d", i), out_data, 8'h10 + i);
            chk($sformatf("rr_in_ready_%0d", i), in_ready, 1);
        end
        in_valid = 1'b0;
        tick();
        chk("rr_sent_cnt", sent_cnt, 11);
        chk("rr_drained", out_valid, 8'h00);

        // Stall on channel 3 while a second item waits upstream.
        mode      = 1'b0;
        in_dest   = 3'd3;
        in_data   = 8'hC3;
        out_ready = 8'hF7;
        in_valid  = 1'b1;
        tick();
        in_dest = 3'd6;
        in_data = 8'h44;
        for (int i = 0; i < 4; i++) begin
            $display("stall cycle %0d valid=%0h data=%0h in_ready=%0b", i, out_valid, out_data, in_ready);
            chk($sformatf("stall_valid_%0d", i), out_valid, 8'h08);
            chk($sformatf("stall_data_%0d", i), out_data, 8'hC3);
            chk($sformatf("stall_sel_%0d", i), out_sel, 3);
            chk($sformatf("stall_in_ready_%0d", i), in_ready, 0);
            chk($sformatf("stall_cnt_%0d", i), sent_cnt, 11);
            tick();
        end

        // Release: delivery of 0xC3 and acceptance of 0x44 on the same edge.
        out_ready = 8'hFF;
        #1;
        chk("release_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("simul_sent_cnt", sent_cnt, 12);
        chk("simul_out_valid", out_valid, 8'h40);
        chk("simul_out_data", out_data, 8'h44);
        chk("simul_out_sel", out_sel, 6);
        tick();
        chk("simul_sent_cnt2", sent_cnt, 13);
        chk("simul_drained", out_valid, 8'h00);

        // 243 more deliveries bring the total to 256: counter wraps to 0.
        in_dest  = 3'd0;
        in_valid = 1'b1;
        for (int i = 0; i < 243; i++) begin
            in_data = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        chk("wrap_pre_cnt", sent_cnt, 8'd255);
        tick();
        $display("wrap sent_cnt=%0d", sent_cnt);
        chk("wrap_sent_cnt", sent_cnt, 0);

        // Mode change takes effect on the next accepted item: rr_ptr is 2.
        mode     = 1'b1;
        in_data  = 8'h66;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("mode_rr_sel", out_sel, 2);
        tick();

        // Reset while holding an item: item discarded, rr_ptr cleared.
        mode      = 1'b0;
        in_dest   = 3'd2;
        in_data   = 8'h77;
        out_ready = 8'h00;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("hold_out_valid", out_valid, 8'h04);
        rst_n = 1'b0;
        tick();
        chk("midrst_out_valid", out_valid, 8'h00);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_sent_cnt", sent_cnt, 0);
        rst_n     = 1'b1;
        out_ready = 8'hFF;
        mode      = 1'b1;
        in_data   = 8'h88;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        $display("post-reset rr sel=%0d valid=%0h data=%0h", out_sel, out_valid, out_data);
        chk("post_rst_rr_sel", out_sel, 0);
        chk("post_rst_rr_valid", out_valid, 8'h01);
        chk("post_rst_rr_data", out_data, 8'h88);
        tick();
        chk("post_rst_sent_cnt", sent_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
